// File: rtl/pal_pkg.sv
// Shared constants and types for the pipe_pal nibble packer.
package pal_pkg;

    localparam int unsigned W_DATA = 32;
    localparam int unsigned N_NIB  = W_DATA / 4;
    localparam int unsigned W_CNT  = $clog2(N_NIB) + 1;

    typedef logic [W_CNT-1:0] cnt_t;

    // Reason a word is closed in the current cycle.
    typedef enum logic [1:0] {
        CMPL_NONE  = 2'd0,
        CMPL_FULL  = 2'd1,
        CMPL_PART  = 2'd2,
        CMPL_FLUSH = 2'd3
    } cmpl_e;

endpackage

// File: rtl/pal_out_reg.sv
// Output holding register: valid/ready handshake plus sticky overflow on dropped words.
module pal_out_reg #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [W_DATA-1:0] load_data,
    input  logic [CNT_W-1:0]  load_nibs,
    input  logic              ready,
    output logic [W_DATA-1:0] data,
    output logic              valid,
    output logic [CNT_W-1:0]  nibs,
    output logic              overflow
);

    logic take_c;
    logic space_c;

    assign take_c  = valid && ready;
    // The register is free if empty or being drained on this same edge.
    assign space_c = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            nibs     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load && space_c) begin
                data  <= load_data;
                nibs  <= load_nibs;
                valid <= 1'b1;
            end else if (take_c) begin
                valid <= 1'b0;
            end
            if (load && !space_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pal_nibble_packer.sv
// Packs 4-bit nibbles into W_DATA-wide words; partial words close on flush strobe b.
module pal_nibble_packer
    import pal_pkg::*;
#(
    parameter int unsigned W_DATA = pal_pkg::W_DATA
) (
    input  logic                            i_clk,
    input  logic                            resetn,
    input  logic                            a,
    input  logic                            b,
    input  logic [3:0]                      c,
    input  logic                            i_ready,
    output logic [W_DATA-1:0]               o_data,
    output logic                            o_valid,
    output logic [$clog2(W_DATA/4):0]       o_nibs,
    output logic [$clog2(W_DATA/4):0]       o_fill,
    output logic                            o_overflow
);

    localparam int unsigned NIBS  = W_DATA / 4;
    localparam int unsigned CNT_W = $clog2(NIBS) + 1;

    logic [W_DATA-1:0] asm_q;
    logic [CNT_W-1:0]  ptr_q;

    cmpl_e             kind_c;
    logic              complete_c;
    logic [W_DATA-1:0] word_c;
    logic [CNT_W-1:0]  nibs_c;
    logic [W_DATA-1:0] asm_nxt_c;
    logic [CNT_W-1:0]  ptr_nxt_c;

    // Classify this cycle's completion in priority order.
    always_comb begin
        kind_c = CMPL_NONE;
        if (a && (ptr_q == CNT_W'(NIBS - 1))) begin
            kind_c = CMPL_FULL;
        end else if (a && b) begin
            kind_c = CMPL_PART;
        end else if (!a && b && (ptr_q != '0)) begin
            kind_c = CMPL_FLUSH;
        end
    end

    assign complete_c = (kind_c != CMPL_NONE);

    // Current buffer with this cycle's nibble merged in at ptr.
    always_comb begin
        word_c = asm_q;
        for (int unsigned i = 0; i < NIBS; i++) begin
            if (a && (ptr_q == CNT_W'(i))) begin
                word_c[4*i +: 4] = c;
            end
        end
    end

    always_comb begin
        nibs_c = '0;
        case (kind_c)
            CMPL_FULL:  nibs_c = CNT_W'(NIBS);
            CMPL_PART:  nibs_c = ptr_q + CNT_W'(1);
            CMPL_FLUSH: nibs_c = ptr_q;
            default:    nibs_c = '0;
        endcase
    end

    always_comb begin
        asm_nxt_c = word_c;
        ptr_nxt_c = ptr_q;
        if (complete_c) begin
            asm_nxt_c = '0;
            ptr_nxt_c = '0;
        end else if (a) begin
            ptr_nxt_c = ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            asm_q <= '0;
            ptr_q <= '0;
        end else begin
            asm_q <= asm_nxt_c;
            ptr_q <= ptr_nxt_c;
        end
    end

    assign o_fill = ptr_q;

    pal_out_reg #(
        .W_DATA (W_DATA),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk       (i_clk),
        .rst_n     (resetn),
        .load      (complete_c),
        .load_data (word_c),
        .load_nibs (nibs_c),
        .ready     (i_ready),
        .data      (o_data),
        .valid     (o_valid),
        .nibs      (o_nibs),
        .overflow  (o_overflow)
    );

endmodule

// File: tb/tb_pal_nibble_packer.sv
// Directed self-checking bench for pal_nibble_packer at W_DATA=32.
module tb_pal_nibble_packer;

    logic        i_clk;
    logic        resetn;
    logic        a;
    logic        b;
    logic [3:0]  c;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_valid;
    logic [3:0]  o_nibs;
    logic [3:0]  o_fill;
    logic        o_overflow;

    int checks;
    int errors;

    pal_nibble_packer #(.W_DATA(32)) dut (
        .i_clk      (i_clk),
        .resetn     (resetn),
        .a          (a),
        .b          (b),
        .c          (c),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_nibs     (o_nibs),
        .o_fill     (o_fill),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic va, input logic vb, input logic [3:0] vc);
        a = va;
        b = vb;
        c = vc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        a = 1'b0;
        b = 1'b0;
        c = 4'h0;
        @(posedge i_clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_data, o_valid, o_nibs, o_fill, o_overflow} !== 42'd0) begin
            errors++;
            $display("FAIL reset_state: data=%h valid=%b nibs=%0d fill=%0d ovf=%b, expected all 0",
                     o_data, o_valid, o_nibs, o_fill, o_overflow);
        end
    endtask

    task automatic test_full_word();
        i_ready = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'(i + 1));
        checks++;
        if (o_valid !== 1'b0 || o_fill !== 4'd7) begin
            errors++;
            $display("FAIL full_before: valid=%b fill=%0d, expected 0/7", o_valid, o_fill);
        end
        step(1'b1, 1'b0, 4'h8);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h87654321 || o_nibs !== 4'd8 || o_fill !== 4'd0) begin
            errors++;
            $display("FAIL full_word: valid=%b data=%h nibs=%0d fill=%0d, expected 1/87654321/8/0",
                     o_valid, o_data, o_nibs, o_fill);
        end
        step(1'b0, 1'b0, 4'h0);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_taken: valid=%b, expected 0", o_valid);
        end
    endtask

    task automatic test_partial_flush();
        i_ready = 1'b1;
        step(1'b1, 1'b0, 4'hA);
        step(1'b1, 1'b0, 4'hB);
        step(1'b1, 1'b1, 4'hC);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h00000CBA || o_nibs !== 4'd3 || o_fill !== 4'd0) begin
            errors++;
            $display("FAIL partial_flush: valid=%b data=%h nibs=%0d fill=%0d, expected 1/00000cba/3/0",
                     o_valid, o_data, o_nibs, o_fill);
        end
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        checks++;
        if (o_valid !== 1'b0 || o_fill !== 4'd0) begin
            errors++;
            $display("FAIL empty_flush: valid=%b fill=%0d, expected 0/0", o_valid, o_fill);
        end
    endtask

    task automatic test_late_flush();
        i_ready = 1'b1;
        step(1'b1, 1'b0, 4'h5);
        step(1'b1, 1'b0, 4'h6);
        step(1'b0, 1'b0, 4'h0);
        checks++;
        if (o_fill !== 4'd2 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_idle: fill=%0d valid=%b, expected 2/0", o_fill, o_valid);
        end
        step(1'b0, 1'b1, 4'h0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h00000065 || o_nibs !== 4'd2 || o_fill !== 4'd0) begin
            errors++;
            $display("FAIL late_flush: valid=%b data=%h nibs=%0d fill=%0d, expected 1/00000065/2/0",
                     o_valid, o_data, o_nibs, o_fill);
        end
        step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 1));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 9));
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h87654321 || o_nibs !== 4'd8 ||
            o_overflow !== 1'b1 || o_fill !== 4'd0) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%b data=%h nibs=%0d ovf=%b fill=%0d, expected 1/87654321/8/1/0",
                     o_valid, o_data, o_nibs, o_overflow, o_fill);
        end
        i_ready = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        checks++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_drain: valid=%b ovf=%b, expected 0/1", o_valid, o_overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 1));
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h87654321) begin
            errors++;
            $display("FAIL b2b_first: valid=%b data=%h, expected 1/87654321", o_valid, o_data);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(8 - i));
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h12345678 || o_nibs !== 4'd8 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%h nibs=%0d ovf=%b, expected 1/12345678/8/0",
                     o_valid, o_data, o_nibs, o_overflow);
        end
        step(1'b0, 1'b0, 4'h0);
    endtask

    // Held word drains on the very edge a new word completes.
    task automatic test_handoff();
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h3);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'h9);
        i_ready = 1'b1;
        step(1'b1, 1'b0, 4'hE);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'hE9999999 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL handoff: valid=%b data=%h ovf=%b, expected 1/e9999999/0",
                     o_valid, o_data, o_overflow);
        end
        step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_reset_mid_word();
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'hF);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({o_data, o_valid, o_nibs, o_fill, o_overflow} !== 42'd0) begin
            errors++;
            $display("FAIL async_reset: data=%h valid=%b nibs=%0d fill=%0d ovf=%b, expected all 0",
                     o_data, o_valid, o_nibs, o_fill, o_overflow);
        end
        @(posedge i_clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 1));
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h87654321 || o_nibs !== 4'd8) begin
            errors++;
            $display("FAIL after_reset: valid=%b data=%h nibs=%0d, expected 1/87654321/8",
                     o_valid, o_data, o_nibs);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        c       = 4'h0;
        i_ready = 1'b0;
        test_reset();
        test_full_word();
        test_partial_flush();
        test_late_flush();
        test_backpressure();
        test_back_to_back();
        test_handoff();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
